lcd_bridge: RTL and testbench

- Sits directly downstream of the I/O address decoder. Consumes its active-high LCD strobe, plus register-select (address bit 0) and the CPU data bus.
- Replays each CPU write to the HD44780-style LCD with legal setup, pulse-width and hold timing.
- Tracks command execution time and stalls the CPU through a wait line (`n_rdy`) if it writes again while the LCD is busy.
- Replaces the decoder's fixed "always ready" behaviour for LCD accesses.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_bridge_if.sv | 27 ++
 rtl/lcd_timer.sv | 31 +++
 rtl/lcd_bridge.sv | 111 +++++++++++
 tb/tb_lcd_bridge.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and timing defaults for the LCD write bridge.
// Long-command detection lives here so the FSM and any checkers agree on it.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      HOLD  = 3'd3,
      EXEC  = 3'd4
   } state_t;

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h02;

   localparam int T_AS_DEF        = 2;
   localparam int T_PW_DEF        = 6;
   localparam int T_H_DEF         = 2;
   localparam int T_EXEC_DEF      = 48;
   localparam int T_EXEC_LONG_DEF = 1640;
   localparam int CW_DEF          = 11;

   // Clear (0x01), home (0x02) and home with the don't-care bit set (0x03).
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
      return !rs && ((d == CMD_CLEAR) || (d == CMD_HOME) || (d == (CMD_CLEAR | CMD_HOME)));
   endfunction

endpackage

// File: rtl/lcd_bridge_if.sv
// CPU-side strobe/bus plus LCD-side pins of the bridge, with the FSM state for debug.
// Handshake: a write is one lcd_e_in strobe; while n_rdy=1 the CPU holds strobe, rs_in and d_in.
interface lcd_bridge_if;
   import lcd_pkg::*;

   logic       lcd_e_in;
   logic       rs_in;
   logic [7:0] d_in;
   logic       n_rdy;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_d;
   logic       busy;
   state_t     state;

   modport master (
      output lcd_e_in, rs_in, d_in,
      input  n_rdy, lcd_rs, lcd_rw, lcd_e, lcd_d, busy, state
   );

   modport slave (
      input  lcd_e_in, rs_in, d_in,
      output n_rdy, lcd_rs, lcd_rw, lcd_e, lcd_d, busy, state
   );

endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter that parks at zero; zero_o flags the terminal count.
module lcd_timer #(
   parameter int CW = 11
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   output logic          zero_o
);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i)
         count_d = load_val_i;
      else if (count_q != '0)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!n_rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_bridge.sv
// Replays CPU writes to an HD44780-style LCD with setup/pulse/hold timing and
// stalls the CPU through n_rdy while the previous command is still executing.
module lcd_bridge
   import lcd_pkg::*;
#(
   parameter int T_AS        = T_AS_DEF,
   parameter int T_PW        = T_PW_DEF,
   parameter int T_H         = T_H_DEF,
   parameter int T_EXEC      = T_EXEC_DEF,
   parameter int T_EXEC_LONG = T_EXEC_LONG_DEF,
   parameter int CW          = CW_DEF
) (
   input  logic         clk,
   input  logic         n_rst,
   lcd_bridge_if.slave  bus
);

   localparam logic [CW-1:0] AS_LD   = CW'(T_AS - 1);
   localparam logic [CW-1:0] PW_LD   = CW'(T_PW - 1);
   localparam logic [CW-1:0] H_LD    = CW'(T_H - 1);
   localparam logic [CW-1:0] EX_LD   = CW'(T_EXEC - 1);
   localparam logic [CW-1:0] EXL_LD  = CW'(T_EXEC_LONG - 1);

   state_t     state_q;
   logic       accepted_q, accepted_d;
   logic       lcd_e_q;
   logic       lcd_rs_q;
   logic [7:0] lcd_d_q;

   logic          accept;
   logic          tmr_load;
   logic [CW-1:0] tmr_val;
   logic          tmr_zero;

   lcd_timer #(.CW(CW)) u_timer (
      .clk        (clk),
      .n_rst      (n_rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   // accepted blocks a strobe that is still high after its own write from retriggering.
   assign accept = bus.lcd_e_in && (state_q == IDLE) && !accepted_q;

   always_comb begin
      if (!bus.lcd_e_in)
         accepted_d = 1'b0;
      else if (accept)
         accepted_d = 1'b1;
      else
         accepted_d = accepted_q;
   end

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         IDLE:  if (accept)   begin tmr_load = 1'b1; tmr_val = AS_LD; end
         SETUP: if (tmr_zero) begin tmr_load = 1'b1; tmr_val = PW_LD; end
         PULSE: if (tmr_zero) begin tmr_load = 1'b1; tmr_val = H_LD;  end
         HOLD:  if (tmr_zero) begin
                   tmr_load = 1'b1;
                   tmr_val  = is_long_cmd(lcd_rs_q, lcd_d_q) ? EXL_LD : EX_LD;
                end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         accepted_q <= 1'b0;
         lcd_e_q    <= 1'b0;
         lcd_rs_q   <= 1'b0;
         lcd_d_q    <= 8'h00;
      end else begin
         accepted_q <= accepted_d;
         case (state_q)
            IDLE: if (accept) begin
               lcd_rs_q <= bus.rs_in;
               lcd_d_q  <= bus.d_in;
               state_q  <= SETUP;
            end
            SETUP: if (tmr_zero) begin
               lcd_e_q <= 1'b1;
               state_q <= PULSE;
            end
            PULSE: if (tmr_zero) begin
               lcd_e_q <= 1'b0;
               state_q <= HOLD;
            end
            HOLD: if (tmr_zero) state_q <= EXEC;
            EXEC: if (tmr_zero) state_q <= IDLE;
            default: begin
               lcd_e_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.n_rdy  = bus.lcd_e_in & ~accepted_q & (state_q != IDLE);
   assign bus.busy   = (state_q != IDLE);
   assign bus.lcd_e  = lcd_e_q;
   assign bus.lcd_rs = lcd_rs_q;
   assign bus.lcd_d  = lcd_d_q;
   assign bus.lcd_rw = 1'b0;
   assign bus.state  = state_q;

endmodule

// File: tb/tb_lcd_bridge.sv
// Directed bench for lcd_bridge: vector table of single writes, plus reset-abort,
// stall and random-write sequences; a negedge monitor checks lcd_e timing.
module tb_lcd_bridge;
   import lcd_pkg::*;

   localparam int TAS = 2;
   localparam int TPW = 6;
   localparam int TH  = 2;

   logic clk = 1'b0;
   logic n_rst = 1'b0;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

   lcd_bridge_if bus ();

   lcd_bridge dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Timing monitor: pulse width, data stability around the pulse, lcd_e only in PULSE.
   logic       prev_e = 1'b0;
   int         hi_cnt = 0;
   int         post = 0;
   logic [8:0] cur, ref_v, hist1, hist2;

   always @(negedge clk) begin
      cur = {bus.lcd_rs, bus.lcd_d};
      if (!n_rst) begin
         hi_cnt = 0;
         post   = 0;
         prev_e = 1'b0;
      end else begin
         if (bus.lcd_e && !prev_e) begin
            pulse_cnt++;
            check("setup_stable_1", {23'd0, hist1}, {23'd0, cur});
            check("setup_stable_2", {23'd0, hist2}, {23'd0, cur});
            ref_v = cur;
         end
         if (bus.lcd_e) begin
            hi_cnt++;
            check("pulse_stable", {23'd0, cur}, {23'd0, ref_v});
            check("e_only_in_pulse", {29'd0, bus.state}, {29'd0, PULSE});
         end
         if (!bus.lcd_e && prev_e) begin
            check("pulse_width", hi_cnt, TPW);
            hi_cnt = 0;
            post   = TH;
         end
         if (post > 0 && !bus.lcd_e) begin
            check("hold_stable", {23'd0, cur}, {23'd0, ref_v});
            post--;
         end
         prev_e = bus.lcd_e;
      end
      hist2 = hist1;
      hist1 = cur;
   end

   // One write with a strobe of len cycles; counts busy cycles and lcd_e pulses.
   task automatic run_vec(input string name, input logic rs, input logic [7:0] d,
                          input int len, input int exp_cyc);
      int p0 = pulse_cnt;
      int bcnt = 0;
      int nrdy_hits = 0;
      @(negedge clk);
      bus.lcd_e_in = 1'b1;
      bus.rs_in    = rs;
      bus.d_in     = d;
      for (int i = 1; i < 4000; i++) begin
         @(negedge clk);
         if (i == 1) begin
            check({name, "_rs"}, {31'd0, bus.lcd_rs}, {31'd0, rs});
            check({name, "_d"}, {24'd0, bus.lcd_d}, {24'd0, d});
         end
         if (bus.busy) bcnt++;
         if (bus.n_rdy) nrdy_hits++;
         if (i == len) bus.lcd_e_in = 1'b0;
         if (i >= len && !bus.busy) break;
      end
      bus.lcd_e_in = 1'b0;
      @(negedge clk);
      check({name, "_busy_cycles"}, bcnt, exp_cyc);
      check({name, "_pulses"}, pulse_cnt - p0, 1);
      check({name, "_nrdy_never"}, nrdy_hits, 0);
   endtask

   typedef struct {
      logic       rs;
      logic [7:0] d;
      int         len;
      int         exp_cyc;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int         p0;
      int         nrdy_cnt;
      logic       rs_r;
      logic [7:0] d_r;

      vecs[0] = '{1'b1, 8'h41, 1,   58};
      vecs[1] = '{1'b0, 8'h01, 1,   1650};
      vecs[2] = '{1'b0, 8'h00, 1,   58};
      vecs[3] = '{1'b0, 8'h04, 1,   58};
      vecs[4] = '{1'b0, 8'h02, 3,   1650};
      vecs[5] = '{1'b0, 8'h03, 1,   1650};
      vecs[6] = '{1'b1, 8'h01, 1,   58};
      vecs[7] = '{1'b1, 8'h00, 2,   58};
      vecs[8] = '{1'b0, 8'hff, 1,   58};
      vecs[9] = '{1'b1, 8'h5a, 100, 58};

      bus.lcd_e_in = 1'b0;
      bus.rs_in    = 1'b0;
      bus.d_in     = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_lcd_e", {31'd0, bus.lcd_e}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_nrdy", {31'd0, bus.n_rdy}, 32'd0);
      check("rst_lcd_d", {24'd0, bus.lcd_d}, 32'd0);
      check("rst_lcd_rs", {31'd0, bus.lcd_rs}, 32'd0);
      check("rst_lcd_rw", {31'd0, bus.lcd_rw}, 32'd0);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 10; v++)
         run_vec($sformatf("vec%0d", v), vecs[v].rs, vecs[v].d, vecs[v].len, vecs[v].exp_cyc);

      // Stall: second write 10 cycles after the first, strobe held while busy.
      p0 = pulse_cnt;
      nrdy_cnt = 0;
      for (int i = 0; i <= 130; i++) begin
         @(negedge clk);
         if (i > 0) begin
            if (bus.n_rdy) nrdy_cnt++;
            if (i == 30) check("stall_d_kept", {24'd0, bus.lcd_d}, 32'h41);
            if (i == 58) begin
               check("stall_nrdy_last", {31'd0, bus.n_rdy}, 32'd1);
               check("stall_busy_last", {31'd0, bus.busy}, 32'd1);
            end
            if (i == 59) begin
               check("stall_nrdy_drop", {31'd0, bus.n_rdy}, 32'd0);
               check("stall_idle", {31'd0, bus.busy}, 32'd0);
            end
            if (i == 60) begin
               check("stall_accept_busy", {31'd0, bus.busy}, 32'd1);
               check("stall_accept_d", {24'd0, bus.lcd_d}, 32'h42);
               check("stall_accept_rs", {31'd0, bus.lcd_rs}, 32'd1);
            end
            if (i == 117) check("stall_second_last", {31'd0, bus.busy}, 32'd1);
            if (i == 118) check("stall_second_done", {31'd0, bus.busy}, 32'd0);
         end
         if (i == 0) begin
            bus.lcd_e_in = 1'b1; bus.rs_in = 1'b1; bus.d_in = 8'h41;
         end
         if (i == 1) bus.lcd_e_in = 1'b0;
         if (i == 10) begin
            bus.lcd_e_in = 1'b1; bus.rs_in = 1'b1; bus.d_in = 8'h42;
         end
         if (i == 60) bus.lcd_e_in = 1'b0;
      end
      check("stall_nrdy_cycles", nrdy_cnt, 48);
      check("stall_pulses", pulse_cnt - p0, 2);

      // Reset mid-PULSE aborts the write.
      @(negedge clk);
      bus.lcd_e_in = 1'b1; bus.rs_in = 1'b1; bus.d_in = 8'h41;
      @(negedge clk);
      bus.lcd_e_in = 1'b0;
      begin
         int k = 0;
         while (!bus.lcd_e && k < 20) begin
            @(negedge clk);
            k++;
         end
         check("rst_reach_pulse", {31'd0, bus.lcd_e}, 32'd1);
      end
      repeat (2) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      check("abort_lcd_e", {31'd0, bus.lcd_e}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_nrdy", {31'd0, bus.n_rdy}, 32'd0);
      check("abort_lcd_d", {24'd0, bus.lcd_d}, 32'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      p0 = pulse_cnt;
      repeat (20) @(negedge clk);
      check("abort_no_completion", {31'd0, bus.busy}, 32'd0);
      check("abort_no_pulse", pulse_cnt - p0, 0);

      // Random normal writes for the timing monitor.
      for (int n = 0; n < 50; n++) begin
         rs_r = 1'($urandom_range(0, 1));
         d_r  = 8'($urandom_range(0, 255));
         if (!rs_r && d_r[7:2] == 6'd0 && d_r != 8'h00) d_r = d_r | 8'h10;
         run_vec($sformatf("rnd%0d", n), rs_r, d_r, int'($urandom_range(1, 4)), 58);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
